hazard_sequencer: RTL and testbench
===================================

Name: hazard_sequencer

Overview:
- Pipeline hazard and stall sequencer for the 5-stage MIPS core; drives freeze, flush and bubble controls into the PC, IF/ID, ID/EX and EX/MEM registers.
- Handles four cases:
  - load-use data hazards
  - RAW hazards when forwarding is disabled
  - taken-branch flushes
  - multi-cycle data-memory waits
- Control state is registered in an FSM; hazard detection in RUN is combinational so controls take effect in the same cycle.

Parameters:
- FLUSH_CYCLES, 1, cycles the flush is held after a taken branch (1..3).
- MEM_TIMEOUT, 15, maximum MEM_WAIT cycles before timeout_err is raised (4-bit counter).

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-low
- forward_en  in  1  forwarding unit enabled
- id_src1  in  5  ID-stage source register 1
- id_src2  in  5  ID-stage source register 2
- id_two_src  in  1  ID instruction reads src2 (not immediate/store-data-only)
- exe_dest  in  5  destination in EXE
- exe_wb_en  in  1  EXE writes back
- exe_mem_r_en  in  1  EXE is a load
- mem_dest  in  5  destination in MEM
- mem_wb_en  in  1  MEM writes back
- br_taken  in  1  branch resolved taken in EXE
- mem_req  in  1  MEM-stage access in flight
- mem_ready  in  1  data memory completes this cycle
- pc_freeze  out  1  hold PC
- ifid_freeze  out  1  hold IF/ID
- ifid_flush  out  1  zero IF/ID
- idex_bubble  out  1  zero ID/EX (ID/EX stall input)
- idex_hold  out  1  hold ID/EX (ID/EX loadForwardStall input)
- exmem_hold  out  1  hold EX/MEM
- state_o  out  3  current FSM state
- timeout_err  out  1  sticky memory-timeout flag

Behaviour:
- Reset (rst=0, any time): state=RUN, counters=0, timeout_err=0. All control outputs are 0 whenever rst=0.
- Register 0 never causes a hazard; all compares require dest!=0.
- Definitions:
  - hz1(x) = (x==exe_dest & exe_wb_en) | (x==mem_dest & mem_wb_en)
  - src2 is checked only when id_two_src=1
- States: RUN=0, LD_STALL=1, RAW_STALL=2, FLUSH=3, MEM_WAIT=4.
- RUN, priority highest first:
  1. mem_req & ~mem_ready: pc_freeze, ifid_freeze, idex_hold and exmem_hold all =1; go to MEM_WAIT; mem counter=1.
  2. br_taken: ifid_flush=1, idex_bubble=1. If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-1; else stay in RUN.
  3. forward_en & exe_mem_r_en & src matches exe_dest: pc_freeze, ifid_freeze and idex_bubble =1; go to LD_STALL.
  4. ~forward_en & hz1(src): pc_freeze, ifid_freeze and idex_bubble =1; go to RAW_STALL.
  5. Otherwise all controls 0.
- LD_STALL: one cycle, all controls 0, return to RUN. Forwarding covers the load in MEM. If mem_req & ~mem_ready, apply the MEM_WAIT controls and go to MEM_WAIT instead.
- RAW_STALL: while hz1 is still true, keep pc_freeze, ifid_freeze and idex_bubble asserted; once clear, return to RUN with controls 0. br_taken in this state behaves as in RUN rule 2 and overrides the stall.
- FLUSH: ifid_flush=1, idex_bubble=1; decrement cnt; go to RUN when cnt reaches 0.
- MEM_WAIT: pc_freeze, ifid_freeze, idex_hold and exmem_hold =1.
  - br_taken is ignored; EXE is frozen and will re-present it.
  - When mem_ready=1, deassert all controls that cycle and return to RUN.
  - When the counter reaches MEM_TIMEOUT, set timeout_err=1 (sticky until reset) and remain in MEM_WAIT. The counter saturates.
- Simultaneous events: idex_hold and idex_bubble are never both 1, because mem wait has priority over bubble. Load-use and RAW checks are suppressed whenever br_taken=1.
- Latency: controls are combinational from state and inputs; FSM transitions take effect on the next posedge.

Optional Feature:
- HAZARD_PERF_CNT_EN defined:
  - Adds three 16-bit saturating counters, incremented by 1 on each cycle their condition holds:
    - stall_cycles: pc_freeze=1 in RUN/LD/RAW
    - flush_cycles: ifid_flush=1
    - memwait_cycles: state=MEM_WAIT
  - Adds output ports perf_stall, perf_flush and perf_memwait (16 bits each).
  - Counters clear on reset.
- Not defined: ports and logic are absent; core behaviour is identical.

Test Plan:
- Load-use, forwarding on: forward_en=1, exe_mem_r_en=1, exe_wb_en=1, exe_dest=5, id_src1=5 -> one cycle with pc_freeze=ifid_freeze=idex_bubble=1, then LD_STALL (state_o=1), then RUN with controls 0.
- No forwarding: forward_en=0, exe_dest=3 with wb for 1 cycle, then mem_dest=3 with wb for 1 cycle, id_src2=3, id_two_src=1 -> bubble held 2 cycles, released on 3rd; id_two_src=0 -> no stall.
- Branch: FLUSH_CYCLES=2, br_taken pulse -> ifid_flush=idex_bubble=1 for exactly 2 cycles, state_o 0->3->0.
- Mem wait: mem_req=1, mem_ready low 3 cycles then high -> idex_hold=exmem_hold=pc_freeze=1 for 3 cycles, all 0 on the ready cycle; br_taken asserted during wait -> no flush.
- Timeout/priority: mem_ready held low 20 cycles -> timeout_err=1 from cycle 15 and sticky; mem_req, br_taken and load-use together in RUN -> MEM_WAIT wins; rst low mid-wait -> all outputs 0 immediately, state_o=0.
- Reg 0: exe_dest=0 with exe_mem_r_en=1, id_src1=0 -> no stall.

Source files
------------

// File: rtl/hazard_sequencer.sv
// Hazard/stall sequencer for the 5-stage MIPS pipeline: load-use, RAW (no forwarding),
// branch flush and data-memory wait control. Optional perf counters: HAZARD_PERF_CNT_EN.
module hazard_sequencer #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        forward_en,
  input  logic [4:0]  id_src1,
  input  logic [4:0]  id_src2,
  input  logic        id_two_src,
  input  logic [4:0]  exe_dest,
  input  logic        exe_wb_en,
  input  logic        exe_mem_r_en,
  input  logic [4:0]  mem_dest,
  input  logic        mem_wb_en,
  input  logic        br_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_freeze,
  output logic        ifid_freeze,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        idex_hold,
  output logic        exmem_hold,
  output logic [2:0]  state_o,
`ifdef HAZARD_PERF_CNT_EN
  output logic [15:0] perf_stall,
  output logic [15:0] perf_flush,
  output logic [15:0] perf_memwait,
`endif
  output logic        timeout_err
);

  // state     | meaning
  // RUN       | normal issue, combinational hazard detection
  // LD_STALL  | one bubble after a load-use stall
  // RAW_STALL | waiting for producer to leave EXE/MEM (no forwarding)
  // FLUSH     | extra flush cycles after a taken branch
  // MEM_WAIT  | pipeline frozen on a multi-cycle data access
  typedef enum logic [2:0] {
    RUN       = 3'd0,
    LD_STALL  = 3'd1,
    RAW_STALL = 3'd2,
    FLUSH     = 3'd3,
    MEM_WAIT  = 3'd4
  } state_t;

  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);
  localparam logic [3:0] MEM_MAX    = 4'(MEM_TIMEOUT);

  state_t     state, state_nx;
  logic [1:0] flush_cnt, flush_cnt_nx;
  logic [3:0] mem_cnt, mem_cnt_nx;
  logic       timeout_q, timeout_nx;
  logic       freeze, flush, bubble, hold;

  logic exe_hit, mem_hit, hz1, mem_stall, load_use, raw_hz;

  assign exe_hit   = (exe_dest != 5'd0) &&
                     ((id_src1 == exe_dest) || (id_two_src && (id_src2 == exe_dest)));
  assign mem_hit   = (mem_dest != 5'd0) &&
                     ((id_src1 == mem_dest) || (id_two_src && (id_src2 == mem_dest)));
  assign hz1       = (exe_hit && exe_wb_en) || (mem_hit && mem_wb_en);
  assign mem_stall = mem_req && !mem_ready;
  assign load_use  = forward_en && exe_mem_r_en && exe_hit;
  assign raw_hz    = !forward_en && hz1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      flush_cnt <= 2'd0;
      mem_cnt   <= 4'd0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nx;
      flush_cnt <= flush_cnt_nx;
      mem_cnt   <= mem_cnt_nx;
      timeout_q <= timeout_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    flush_cnt_nx = flush_cnt;
    mem_cnt_nx   = mem_cnt;
    freeze       = 1'b0;
    flush        = 1'b0;
    bubble       = 1'b0;
    hold         = 1'b0;
    unique case (state)
      RUN, LD_STALL, RAW_STALL: begin
        if (mem_stall && state != RAW_STALL) begin
          freeze     = 1'b1;
          hold       = 1'b1;
          state_nx   = MEM_WAIT;
          mem_cnt_nx = 4'd1;
        end else if (br_taken && state != LD_STALL) begin
          flush  = 1'b1;
          bubble = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_nx     = FLUSH;
            flush_cnt_nx = FLUSH_INIT;
          end else begin
            state_nx = RUN;
          end
        end else if (state == RUN && load_use) begin
          freeze   = 1'b1;
          bubble   = 1'b1;
          state_nx = LD_STALL;
        end else if ((state == RUN && raw_hz) || (state == RAW_STALL && hz1)) begin
          freeze   = 1'b1;
          bubble   = 1'b1;
          state_nx = RAW_STALL;
        end else begin
          state_nx = RUN;
        end
      end
      FLUSH: begin
        flush        = 1'b1;
        bubble       = 1'b1;
        flush_cnt_nx = flush_cnt - 2'd1;
        if (flush_cnt <= 2'd1) state_nx = RUN;
      end
      MEM_WAIT: begin
        // EXE is frozen during the wait, so a branch seen here is re-presented later.
        if (mem_ready) begin
          state_nx = RUN;
        end else begin
          freeze = 1'b1;
          hold   = 1'b1;
          if (mem_cnt != MEM_MAX) mem_cnt_nx = mem_cnt + 4'd1;
        end
      end
      default: state_nx = RUN;
    endcase
    timeout_nx = timeout_q || (state_nx == MEM_WAIT && mem_cnt_nx == MEM_MAX);
  end

  assign pc_freeze   = rst && freeze;
  assign ifid_freeze = rst && freeze;
  assign ifid_flush  = rst && flush;
  assign idex_bubble = rst && bubble;
  assign idex_hold   = rst && hold;
  assign exmem_hold  = rst && hold;
  assign state_o     = state;
  assign timeout_err = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic stall_inc, memwait_inc;
  assign stall_inc   = pc_freeze && (state == RUN || state == LD_STALL || state == RAW_STALL);
  assign memwait_inc = (state == MEM_WAIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall   <= 16'd0;
      perf_flush   <= 16'd0;
      perf_memwait <= 16'd0;
    end else begin
      if (stall_inc && perf_stall != 16'hFFFF)     perf_stall   <= perf_stall + 16'd1;
      if (ifid_flush && perf_flush != 16'hFFFF)    perf_flush   <= perf_flush + 16'd1;
      if (memwait_inc && perf_memwait != 16'hFFFF) perf_memwait <= perf_memwait + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer (FLUSH_CYCLES=2): directed cycles push expected
// control vectors; a negedge monitor pops and compares them against the DUT.
module tb_hazard_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       forward_en, id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
  logic       br_taken, mem_req, mem_ready;
  logic [4:0] id_src1, id_src2, exe_dest, mem_dest;
  logic       pc_freeze, ifid_freeze, ifid_flush, idex_bubble, idex_hold, exmem_hold;
  logic [2:0] state_o;
  logic       timeout_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] perf_stall, perf_flush, perf_memwait;
`endif

  always #5 clk = ~clk;

  hazard_sequencer #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .forward_en(forward_en),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .br_taken(br_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_freeze(pc_freeze), .ifid_freeze(ifid_freeze), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .idex_hold(idex_hold), .exmem_hold(exmem_hold),
    .state_o(state_o),
`ifdef HAZARD_PERF_CNT_EN
    .perf_stall(perf_stall), .perf_flush(perf_flush), .perf_memwait(perf_memwait),
`endif
    .timeout_err(timeout_err)
  );

  // {pc_freeze, ifid_freeze, ifid_flush, idex_bubble, idex_hold, exmem_hold}
  localparam logic [5:0] C0  = 6'b000000;
  localparam logic [5:0] CST = 6'b110100;
  localparam logic [5:0] CFL = 6'b001100;
  localparam logic [5:0] CMW = 6'b110011;

  logic [9:0] exp_q[$];
  string      nm_q[$];
  int         n_cmp = 0;
  int         n_fail = 0;

  initial begin
    logic [9:0] e, act;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        nm  = nm_q.pop_front();
        act = {pc_freeze, ifid_freeze, ifid_flush, idex_bubble, idex_hold, exmem_hold,
               state_o, timeout_err};
        n_cmp++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL %s: got ctl=%b st=%0d to=%b, want ctl=%b st=%0d to=%b",
                   nm, act[9:4], act[3:1], act[0], e[9:4], e[3:1], e[0]);
        end
      end
    end
  end

  task automatic idle();
    forward_en = 1'b1; id_two_src = 1'b0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
    mem_wb_en = 1'b0; br_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    id_src1 = 5'd0; id_src2 = 5'd0; exe_dest = 5'd0; mem_dest = 5'd0;
  endtask

  task automatic load_use(input logic [4:0] r);
    forward_en = 1'b1; exe_mem_r_en = 1'b1; exe_wb_en = 1'b1; exe_dest = r; id_src1 = r;
  endtask

  task automatic chk(input string nm, input logic [5:0] ctl, input logic [2:0] st,
                     input logic to);
    exp_q.push_back({ctl, st, to});
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    @(posedge clk);
    #1;
    // reset gating: a live load-use hazard must not reach the outputs
    load_use(5'd5);
    chk("rst_gate", C0, 3'd0, 1'b0);
    chk("rst_gate2", C0, 3'd0, 1'b0);
    rst = 1'b1;
    idle();
    chk("idle", C0, 3'd0, 1'b0);

    load_use(5'd5);
    chk("lu_stall", CST, 3'd0, 1'b0);
    idle();
    chk("lu_ldstall", C0, 3'd1, 1'b0);
    chk("lu_run", C0, 3'd0, 1'b0);

    idle(); forward_en = 1'b0; id_two_src = 1'b1; id_src2 = 5'd3; id_src1 = 5'd9;
    exe_dest = 5'd3; exe_wb_en = 1'b1;
    chk("raw_exe", CST, 3'd0, 1'b0);
    exe_dest = 5'd0; exe_wb_en = 1'b0; mem_dest = 5'd3; mem_wb_en = 1'b1;
    chk("raw_mem", CST, 3'd2, 1'b0);
    mem_dest = 5'd0; mem_wb_en = 1'b0;
    chk("raw_release", C0, 3'd2, 1'b0);
    chk("raw_run", C0, 3'd0, 1'b0);
    id_two_src = 1'b0; exe_dest = 5'd3; exe_wb_en = 1'b1; id_src1 = 5'd7;
    chk("raw_one_src", C0, 3'd0, 1'b0);

    idle(); load_use(5'd0);
    chk("reg0_lu", C0, 3'd0, 1'b0);
    forward_en = 1'b0;
    chk("reg0_raw", C0, 3'd0, 1'b0);

    idle(); load_use(5'd6); br_taken = 1'b1;
    chk("br_flush1", CFL, 3'd0, 1'b0);
    idle();
    chk("br_flush2", CFL, 3'd3, 1'b0);
    chk("br_done", C0, 3'd0, 1'b0);

    idle(); mem_req = 1'b1;
    chk("mw_enter", CMW, 3'd0, 1'b0);
    br_taken = 1'b1;
    chk("mw_br_ign", CMW, 3'd4, 1'b0);
    chk("mw_wait3", CMW, 3'd4, 1'b0);
    br_taken = 1'b0; mem_ready = 1'b1;
    chk("mw_ready", C0, 3'd4, 1'b0);
    idle();
    chk("mw_run", C0, 3'd0, 1'b0);

    idle(); forward_en = 1'b0; exe_dest = 5'd4; exe_wb_en = 1'b1; id_src1 = 5'd4;
    chk("raw2_stall", CST, 3'd0, 1'b0);
    exe_wb_en = 1'b0; mem_dest = 5'd4; mem_wb_en = 1'b1; br_taken = 1'b1;
    chk("raw2_br", CFL, 3'd2, 1'b0);
    idle();
    chk("raw2_flush", CFL, 3'd3, 1'b0);
    chk("raw2_run", C0, 3'd0, 1'b0);

    // everything at once in RUN: memory wait wins, branch and load-use ignored
    idle(); load_use(5'd8); br_taken = 1'b1; mem_req = 1'b1;
    for (int i = 1; i <= 20; i++)
      chk("to_wait", CMW, (i == 1) ? 3'd0 : 3'd4, (i >= 16));
    idle(); mem_ready = 1'b1; mem_req = 1'b1;
    chk("to_ready", C0, 3'd4, 1'b1);
    idle();
    chk("to_sticky", C0, 3'd0, 1'b1);
    mem_req = 1'b1;
    chk("to_rewait", CMW, 3'd0, 1'b1);
    chk("to_rewait2", CMW, 3'd4, 1'b1);
    rst = 1'b0;
    chk("rst_mid", C0, 3'd0, 1'b0);
    chk("rst_mid2", C0, 3'd0, 1'b0);
    rst = 1'b1;
    idle();
    chk("post_rst", C0, 3'd0, 1'b0);

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
